// File: rtl/stepdir_decoder_if.sv
// Step/dir decoder bus: pin-side controls in, position/period/status out.
interface stepdir_decoder_if;
  logic        step;
  logic        dir;
  logic        enable;
  logic        clear;
  logic        err_clr;
  logic [31:0] position;
  logic [31:0] period;
  logic        step_valid;
  logic        err_setup;
  logic        err_width;

  modport master (
    output step, dir, enable, clear, err_clr,
    input  position, period, step_valid, err_setup, err_width
  );

  modport slave (
    input  step, dir, enable, clear, err_clr,
    output position, period, step_valid, err_setup, err_width
  );
endinterface

// File: rtl/stepdir_decoder.sv
// Step/dir pin decoder: synchronizes the pins, validates step width and dir
// setup, and maintains a signed position plus inter-step period.
module stepdir_decoder #(
  parameter int CLK_FREQ   = 100000000,
  parameter int STEP_DEDGE = 0,
  parameter int MIN_HIGH   = 5,
  parameter int DIR_SETUP  = 4
) (
  input logic                clk,
  input logic                resetn,
  stepdir_decoder_if.slave   bus
);

  // The level counter also times synchronizer priming after reset, so it must reach 2.
  localparam int LVL_MAX = (MIN_HIGH > 2) ? MIN_HIGH : 2;
  localparam int LW      = $clog2(LVL_MAX + 1);
  localparam int DW      = $clog2(DIR_SETUP + 2);

  localparam logic [LW-1:0] LVL_MAX_L   = LW'(LVL_MAX);
  localparam logic [LW-1:0] MIN_HIGH_L  = LW'(MIN_HIGH);
  localparam logic [LW-1:0] PRIMED_L    = LW'(2);
  localparam logic [DW-1:0] DIR_SETUP_L = DW'(DIR_SETUP);

  generate
    if (CLK_FREQ <= 0) begin : g_bad_clk_freq
    end
  endgenerate

  typedef enum logic [1:0] {WAIT_LOW, LOW, HIGH} state_t;

  state_t          state_reg;
  logic            step_s1, step_s2;
  logic            dir_s1, dir_s2;
  logic [LW-1:0]   lvl_cnt_reg;
  logic [DW-1:0]   dir_cnt_reg;
  logic [31:0]     timer_reg;
  logic [31:0]     position_reg;
  logic [31:0]     period_reg;
  logic            step_valid_reg;
  logic            err_setup_reg;
  logic            err_width_reg;

  logic            rise, fall, counted, take;
  logic            width_bad, setup_bad;
  logic [31:0]     timer_inc;
  logic [LW-1:0]   lvl_inc;

  assign rise      = (state_reg == LOW)  &&  step_s2;
  assign fall      = (state_reg == HIGH) && !step_s2;
  assign counted   = rise || ((STEP_DEDGE != 0) && fall);
  assign take      = counted && bus.enable;
  assign width_bad = bus.enable && (fall || ((STEP_DEDGE != 0) && rise)) &&
                     (lvl_cnt_reg < MIN_HIGH_L);
  assign setup_bad = take && (dir_cnt_reg < DIR_SETUP_L);
  assign timer_inc = (timer_reg == 32'hFFFF_FFFF) ? timer_reg : timer_reg + 32'd1;
  assign lvl_inc   = (lvl_cnt_reg == LVL_MAX_L) ? lvl_cnt_reg : lvl_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      dir_s1  <= 1'b0;
      dir_s2  <= 1'b0;
    end else begin
      step_s1 <= bus.step;
      step_s2 <= step_s1;
      dir_s1  <= bus.dir;
      dir_s2  <= dir_s1;
    end
  end

  // dir_s2 is about to change whenever s1 and s2 differ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dir_cnt_reg <= '0;
    end else if (dir_s1 != dir_s2) begin
      dir_cnt_reg <= '0;
    end else if (dir_cnt_reg != DIR_SETUP_L) begin
      dir_cnt_reg <= dir_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= WAIT_LOW;
      lvl_cnt_reg    <= '0;
      step_valid_reg <= 1'b0;
    end else begin
      step_valid_reg <= take && !bus.clear;
      case (state_reg)
        WAIT_LOW: begin
          if (!step_s2 && (lvl_cnt_reg >= PRIMED_L)) begin
            state_reg   <= LOW;
            lvl_cnt_reg <= LW'(1);
          end else begin
            lvl_cnt_reg <= lvl_inc;
          end
        end
        LOW: begin
          if (step_s2) begin
            state_reg   <= HIGH;
            lvl_cnt_reg <= LW'(1);
          end else begin
            lvl_cnt_reg <= lvl_inc;
          end
        end
        HIGH: begin
          if (!step_s2) begin
            state_reg   <= LOW;
            lvl_cnt_reg <= LW'(1);
          end else begin
            lvl_cnt_reg <= lvl_inc;
          end
        end
        default: begin
          state_reg   <= WAIT_LOW;
          lvl_cnt_reg <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      position_reg  <= '0;
      period_reg    <= 32'hFFFF_FFFF;
      timer_reg     <= 32'hFFFF_FFFF;
      err_setup_reg <= 1'b0;
      err_width_reg <= 1'b0;
    end else begin
      if (bus.clear) begin
        // A step coinciding with clear is dropped; next period reads as "unknown".
        position_reg <= '0;
        timer_reg    <= 32'hFFFF_FFFF;
      end else if (take) begin
        position_reg <= dir_s2 ? position_reg - 32'd1 : position_reg + 32'd1;
        period_reg   <= timer_inc;
        timer_reg    <= '0;
      end else begin
        timer_reg <= timer_inc;
      end

      if (setup_bad)        err_setup_reg <= 1'b1;
      else if (bus.err_clr) err_setup_reg <= 1'b0;

      if (width_bad)        err_width_reg <= 1'b1;
      else if (bus.err_clr) err_width_reg <= 1'b0;
    end
  end

  assign bus.position   = position_reg;
  assign bus.period     = period_reg;
  assign bus.step_valid = step_valid_reg;
  assign bus.err_setup  = err_setup_reg;
  assign bus.err_width  = err_width_reg;

endmodule

// File: tb/tb_stepdir_decoder.sv
// Self-checking bench for stepdir_decoder: vector table, corner sequences, random pulses.
module tb_stepdir_decoder;

  logic clk;
  logic resetn;
  int   tests = 0;
  int   fails = 0;
  int   sv0   = 0;
  int   sv1   = 0;

  stepdir_decoder_if if0();
  stepdir_decoder_if if1();

  assign if1.step    = if0.step;
  assign if1.dir     = if0.dir;
  assign if1.enable  = if0.enable;
  assign if1.clear   = if0.clear;
  assign if1.err_clr = if0.err_clr;

  stepdir_decoder #(.STEP_DEDGE(0)) u0 (.clk(clk), .resetn(resetn), .bus(if0));
  stepdir_decoder #(.STEP_DEDGE(1)) u1 (.clk(clk), .resetn(resetn), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if0.step_valid) sv0 <= sv0 + 1;
    if (if1.step_valid) sv1 <= sv1 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        d;
    int          lead;
    int          lo;
    int          hi;
    logic        en;
    logic        clr;
    logic        eclr;
    logic [31:0] pos;
    logic [31:0] per;
    logic        es;
    logic        ew;
    int          sv;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Low phase of lo clocks (dir set lead clocks before the rise), hi clocks high, 4 clocks settle.
  task automatic pulse(input logic d, input int lead, input int lo, input int hi,
                       input logic en, input logic clr, input logic eclr);
    if0.enable = en;
    for (int i = 0; i < lo; i++) begin
      if0.clear   = (i == 0) && clr;
      if0.err_clr = (i == 0) && eclr;
      if (lead > 0 && i == lo - lead) if0.dir = d;
      tick();
    end
    if0.clear   = 1'b0;
    if0.err_clr = 1'b0;
    if (lead == 0) if0.dir = d;
    if0.step = 1'b1;
    repeat (hi) tick();
    if0.step = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int          sb;
    int          sb1;
    logic        cur_dir;
    logic [31:0] m_pos;
    logic [31:0] m_per;
    int          prev_hi;

    //           d     lead lo  hi  en    clr   eclr  pos            per            es    ew   sv
    tbl[0]  = '{1'b0, -1,  6,  10, 1'b1, 1'b0, 1'b0, 32'd1,         32'hFFFFFFFF, 1'b0, 1'b0, 1};
    tbl[1]  = '{1'b0, -1,  6,  10, 1'b1, 1'b0, 1'b0, 32'd2,         32'd20,       1'b0, 1'b0, 1};
    tbl[2]  = '{1'b0, -1,  6,  10, 1'b1, 1'b0, 1'b0, 32'd3,         32'd20,       1'b0, 1'b0, 1};
    tbl[3]  = '{1'b0, -1,  6,  10, 1'b1, 1'b0, 1'b0, 32'd4,         32'd20,       1'b0, 1'b0, 1};
    tbl[4]  = '{1'b0, -1,  6,  10, 1'b1, 1'b0, 1'b0, 32'd5,         32'd20,       1'b0, 1'b0, 1};
    tbl[5]  = '{1'b1,  5,  6,  10, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b0,  5,  6,  10, 1'b1, 1'b0, 1'b0, 32'd0,         32'd20,       1'b0, 1'b0, 1};
    tbl[7]  = '{1'b0, -1,  6,  10, 1'b1, 1'b0, 1'b0, 32'd1,         32'd20,       1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1,  2,  6,  10, 1'b1, 1'b0, 1'b0, 32'd0,         32'd20,       1'b1, 1'b0, 1};
    tbl[9]  = '{1'b1, -1,  6,  10, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF,  32'd20,       1'b0, 1'b0, 1};
    tbl[10] = '{1'b0,  5,  6,  2,  1'b1, 1'b0, 1'b0, 32'd0,         32'd20,       1'b0, 1'b1, 1};
    tbl[11] = '{1'b0, -1,  6,  5,  1'b1, 1'b0, 1'b1, 32'd1,         32'd12,       1'b0, 1'b0, 1};
    tbl[12] = '{1'b1,  4,  6,  5,  1'b1, 1'b0, 1'b0, 32'd0,         32'd15,       1'b0, 1'b0, 1};
    tbl[13] = '{1'b0,  3,  6,  4,  1'b1, 1'b0, 1'b0, 32'd1,         32'd15,       1'b1, 1'b1, 1};
    tbl[14] = '{1'b0, -1,  6,  4,  1'b0, 1'b0, 1'b1, 32'd1,         32'd15,       1'b0, 1'b0, 0};
    tbl[15] = '{1'b0, -1,  6,  10, 1'b1, 1'b0, 1'b0, 32'd2,         32'd28,       1'b0, 1'b0, 1};

    resetn      = 1'b0;
    if0.step    = 1'b0;
    if0.dir     = 1'b0;
    if0.enable  = 1'b1;
    if0.clear   = 1'b0;
    if0.err_clr = 1'b0;
    repeat (3) tick();
    chk("reset_position", if0.position, 32'd0);
    chk("reset_period", if0.period, 32'hFFFFFFFF);
    chk("reset_step_valid", {31'd0, if0.step_valid}, 32'd0);
    chk("reset_err_setup", {31'd0, if0.err_setup}, 32'd0);
    chk("reset_err_width", {31'd0, if0.err_width}, 32'd0);
    chk("reset_dedge_period", if1.period, 32'hFFFFFFFF);
    resetn = 1'b1;
    repeat (10) tick();

    foreach (tbl[k]) begin
      sb = sv0;
      pulse(tbl[k].d, tbl[k].lead, tbl[k].lo, tbl[k].hi, tbl[k].en, tbl[k].clr, tbl[k].eclr);
      $display("[TB] vec %0d d=%0b lead=%0d lo=%0d hi=%0d en=%0b pos=%0h per=%0h es=%0b ew=%0b",
               k, tbl[k].d, tbl[k].lead, tbl[k].lo, tbl[k].hi, tbl[k].en,
               if0.position, if0.period, if0.err_setup, if0.err_width);
      chk($sformatf("vec%0d_steps", k), 32'(sv0 - sb), 32'(tbl[k].sv));
      chk($sformatf("vec%0d_position", k), if0.position, tbl[k].pos);
      chk($sformatf("vec%0d_period", k), if0.period, tbl[k].per);
      chk($sformatf("vec%0d_err_setup", k), {31'd0, if0.err_setup}, {31'd0, tbl[k].es});
      chk($sformatf("vec%0d_err_width", k), {31'd0, if0.err_width}, {31'd0, tbl[k].ew});
    end
    if0.enable = 1'b1;

    // Step held high through reset release must not count until seen low then high.
    if0.step = 1'b1;
    resetn   = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    sb = sv0;
    repeat (10) tick();
    chk("held_high_no_step", 32'(sv0 - sb), 32'd0);
    chk("held_high_position", if0.position, 32'd0);
    if0.step = 1'b0;
    repeat (10) tick();
    if0.step = 1'b1;
    tick();
    tick();
    chk("latency_edge2_valid", {31'd0, if0.step_valid}, 32'd0);
    tick();
    chk("latency_edge3_valid", {31'd0, if0.step_valid}, 32'd1);
    chk("latency_edge3_position", if0.position, 32'd1);
    tick();
    chk("latency_edge4_valid", {31'd0, if0.step_valid}, 32'd0);
    $display("[TB] held-high reset sequence pos=%0h", if0.position);
    repeat (6) tick();
    if0.step = 1'b0;
    repeat (6) tick();

    // Double-edge instance: two pulses give four steps.
    if0.dir = 1'b0;
    resetn  = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (10) tick();
    sb1 = sv1;
    pulse(1'b0, -1, 6, 10, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, -1, 6, 10, 1'b1, 1'b0, 1'b0);
    $display("[TB] dedge two pulses pos=%0h steps=%0d", if1.position, sv1 - sb1);
    chk("dedge_position", if1.position, 32'd4);
    chk("dedge_steps", 32'(sv1 - sb1), 32'd4);
    chk("dedge_err_width", {31'd0, if1.err_width}, 32'd0);
    chk("dedge_err_setup", {31'd0, if1.err_setup}, 32'd0);

    // Clear coinciding with a counted edge drops the step.
    sb  = sv0;
    sb1 = sv1;
    if0.step = 1'b1;
    tick();
    tick();
    if0.clear = 1'b1;
    tick();
    if0.clear = 1'b0;
    chk("clear_edge_dedge_position", if1.position, 32'd0);
    chk("clear_edge_position", if0.position, 32'd0);
    repeat (8) tick();
    chk("clear_edge_dedge_no_step", 32'(sv1 - sb1), 32'd0);
    chk("clear_edge_no_step", 32'(sv0 - sb), 32'd0);
    if0.step = 1'b0;
    repeat (6) tick();
    $display("[TB] clear-on-edge pos=%0h per=%0h", if1.position, if1.period);
    chk("after_clear_dedge_position", if1.position, 32'd1);
    chk("after_clear_dedge_period", if1.period, 32'hFFFFFFFF);
    chk("after_clear_dedge_steps", 32'(sv1 - sb1), 32'd1);

    // Random pulses against a pulse-level model.
    cur_dir = 1'b0;
    m_pos   = 32'd0;
    prev_hi = 0;
    for (int k = 0; k < 40; k++) begin
      logic d;
      int   lo, hi, lead;
      logic exp_es, exp_ew;
      d    = 1'($urandom_range(0, 1));
      lo   = int'($urandom_range(1, 8));
      hi   = int'($urandom_range(1, 12));
      lead = (d != cur_dir) ? int'($urandom_range(0, lo)) : -1;
      sb   = sv0;
      pulse(d, lead, lo, hi, 1'b1, k == 0, 1'b1);
      if (k == 0) m_pos = 32'd0;
      m_pos   = d ? m_pos - 32'd1 : m_pos + 32'd1;
      m_per   = (k == 0) ? 32'hFFFFFFFF : 32'(prev_hi + 4 + lo);
      exp_es  = (lead >= 0) && (lead < 4);
      exp_ew  = hi < 5;
      cur_dir = d;
      prev_hi = hi;
      $display("[TB] rnd %0d d=%0b lead=%0d lo=%0d hi=%0d pos=%0h per=%0h es=%0b ew=%0b",
               k, d, lead, lo, hi, if0.position, if0.period, if0.err_setup, if0.err_width);
      chk($sformatf("rnd%0d_steps", k), 32'(sv0 - sb), 32'd1);
      chk($sformatf("rnd%0d_position", k), if0.position, m_pos);
      chk($sformatf("rnd%0d_period", k), if0.period, m_per);
      chk($sformatf("rnd%0d_err_setup", k), {31'd0, if0.err_setup}, {31'd0, exp_es});
      chk($sformatf("rnd%0d_err_width", k), {31'd0, if0.err_width}, {31'd0, exp_ew});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stepdir_decoder.md
STEPDIR_DECODER -- requirements
Module: stepdir_decoder

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- CLK_FREQ, 100000000, clk frequency in Hz (informational).
- STEP_DEDGE, 0, 1 = both step edges count as steps.
- MIN_HIGH, 5, minimum step level duration in clocks.
- DIR_SETUP, 4, minimum clocks dir must be stable before a counted step edge.

REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- step  in  1  asynchronous step pin.
- dir  in  1  asynchronous dir pin; 0 = +1 step, 1 = -1 step.
- enable  in  1  when 0, edges are ignored.
- clear  in  1  synchronous pulse; zeroes position.
- err_clr  in  1  synchronous pulse; clears sticky errors.
- position  out  32  signed step count.
- period  out  32  clocks between the last two counted steps.
- step_valid  out  1  one-cycle pulse per counted step.
- err_setup  out  1  sticky dir-setup violation.
- err_width  out  1  sticky pulse-width violation.

Function
REQ-003 SHALL pass step and dir each through a 2-FF synchronizer (s1, s2); all logic below uses s2 only.
REQ-004 SHALL run a step FSM with states WAIT_LOW, LOW, HIGH; reset enters WAIT_LOW.
REQ-005 SHALL move WAIT_LOW -> LOW only when step_s2 = 0; no edge is counted while in WAIT_LOW.
REQ-006 SHALL move LOW -> HIGH on step_s2 = 1 and HIGH -> LOW on step_s2 = 0.
REQ-007 SHALL treat LOW -> HIGH as a counted edge; with STEP_DEDGE = 1, HIGH -> LOW is also a counted edge.
REQ-008 SHALL count clocks spent in the current level (saturating at MIN_HIGH) and set err_width when leaving HIGH with count < MIN_HIGH (and leaving LOW, if STEP_DEDGE = 1).
REQ-009 SHALL register step_valid high for exactly one cycle per counted edge when enable = 1.
- Latency: step_valid is high in the cycle after the 3rd rising clk edge at which the step pin is sampled at its new level.
REQ-010 SHALL on each counted step update position by +1 if dir_s2 = 0 and -1 if dir_s2 = 1.
- Arithmetic is two's-complement 32-bit with wrap: 0x7FFFFFFF + 1 = 0x80000000; 0 - 1 = 0xFFFFFFFF.
REQ-011 SHALL count clocks since the last dir_s2 change, saturating at DIR_SETUP.
- On a counted step with count < DIR_SETUP, set err_setup; the step is still counted, using the current dir_s2.
REQ-012 SHALL keep a 32-bit period timer that increments every clock and saturates at 0xFFFFFFFF.
- On a counted step: period <= timer + 1 (saturating), timer <= 0.
REQ-013 SHALL report period = 0xFFFFFFFF for the first counted step after reset or clear.
REQ-014 SHALL, when enable = 0, keep the FSM tracking levels, and SHALL NOT:
- assert step_valid;
- change position or period;
- set errors.
REQ-015 SHALL, if clear and a counted edge coincide: set position to 0, drop the step (no step_valid), and mark the period timer saturated.
REQ-016 SHALL give error set priority over err_clr in the same cycle.
REQ-017 SHALL, when dir changes in the same cycle as a counted edge, count using the new dir_s2 and set err_setup.

Reset
REQ-018 SHALL, while resetn = 0, force:
- synchronizers = 0;
- FSM = WAIT_LOW;
- position = 0, period = 0xFFFFFFFF, step_valid = 0;
- err_setup = 0, err_width = 0;
- level and dir counters = 0;
- period timer saturated.
REQ-019 SHALL resume on the first rising clk edge after resetn deasserts.
- A step held high across reset release is not counted until it has been seen low and then high again.

Verification
REQ-020 Reset, dir = 0, 5 pulses (10 clk high / 10 clk low) -> 5 step_valid pulses, position = 5, period = 0xFFFFFFFF after step 1 and 20 after steps 2-5, no errors.
REQ-021 From position 0, dir = 1, 1 pulse -> position = 0xFFFFFFFF; then dir = 0, 2 pulses -> position = 1.
REQ-022 DIR_SETUP = 4, dir toggled 2 clocks before step rise -> err_setup = 1 and step counted with new dir; err_clr pulse -> err_setup = 0.
REQ-023 Step high for 2 clocks, MIN_HIGH = 5 -> err_width = 1 and position still +1.
REQ-024 Step held high through resetn release -> no step_valid; then step low for 10 clocks and high -> position = 1.
REQ-025 STEP_DEDGE = 1, 2 full pulses, dir = 0 -> position = 4; clear asserted in the cycle of a counted edge -> position = 0 and no step_valid.
